// File: rtl/ahb5_manager_engine.sv
// rtl/ahb5_manager_engine.sv - AHB5 manager burst engine
// Issues one command as a pipelined AHB burst; reports read beats, write pops and completion.
module ahb5_manager_engine #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic                      cmd_write,
    input  logic [2:0]                cmd_size,
    input  logic [HBURST_WIDTH-1:0]   cmd_burst,
    input  logic [3:0]                cmd_len,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_pop,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [HBURST_WIDTH-1:0]   HBURST,
    output logic [DATA_WIDTH-1:0]     HWDATA,
    output logic [DATA_WIDTH/8-1:0]   HWSTRB,
    input  logic                      HREADY,
    input  logic                      HRESP,
    input  logic [DATA_WIDTH-1:0]     HRDATA
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PIPE,
        ST_LAST,
        ST_ERR2
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     haddr_q, haddr_d;
    logic [1:0]                htrans_q, htrans_d;
    logic                      hwrite_q, hwrite_d;
    logic [2:0]                hsize_q, hsize_d;
    logic [HBURST_WIDTH-1:0]   hburst_q, hburst_d;
    logic [DATA_WIDTH-1:0]     hwdata_q, hwdata_d;
    logic [STRB_W-1:0]         hwstrb_q, hwstrb_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic [4:0]                beats_q, beats_d;

    logic [ADDR_WIDTH-1:0]     incr, sum, wrap_bytes, wrap_mask, next_addr;
    logic [STRB_W-1:0]         strb;
    logic [4:0]                cmd_beats;
    logic                      advance;

    always_comb begin
        case (3'(cmd_burst))
            3'd0:         cmd_beats = 5'd1;
            3'd1:         cmd_beats = {1'b0, cmd_len} + 5'd1;
            3'd2, 3'd3:   cmd_beats = 5'd4;
            3'd4, 3'd5:   cmd_beats = 5'd8;
            default:      cmd_beats = 5'd16;
        endcase
    end

    // Wrapping bursts keep the bits above the wrap boundary and roll the low bits.
    always_comb begin
        incr = ADDR_WIDTH'(1) << hsize_q;
        sum  = haddr_q + incr;
        case (3'(hburst_q))
            3'd2:    wrap_bytes = ADDR_WIDTH'(4) << hsize_q;
            3'd4:    wrap_bytes = ADDR_WIDTH'(8) << hsize_q;
            3'd6:    wrap_bytes = ADDR_WIDTH'(16) << hsize_q;
            default: wrap_bytes = '0;
        endcase
        wrap_mask = wrap_bytes - ADDR_WIDTH'(1);
        if (wrap_bytes != '0) begin
            next_addr = (haddr_q & ~wrap_mask) | (sum & wrap_mask);
        end else begin
            next_addr = sum;
        end
    end

    always_comb begin
        case (hsize_q)
            3'd0:    strb = STRB_W'(1);
            3'd1:    strb = STRB_W'(3);
            default: strb = '1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        hwstrb_d   = hwstrb_q;
        rd_data_d  = rd_data_q;
        beats_d    = beats_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_pop     = 1'b0;
        advance    = 1'b0;
        HTRANS     = htrans_q;

        case (state_q)
            ST_IDLE: begin
                htrans_d = TR_IDLE;
                if (cmd_ready_q && cmd_valid) begin
                    haddr_d  = cmd_addr;
                    htrans_d = TR_NONSEQ;
                    hwrite_d = cmd_write;
                    hsize_d  = cmd_size;
                    hburst_d = cmd_burst;
                    beats_d  = cmd_beats;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                advance = HREADY;
            end
            ST_PIPE: begin
                if (!HREADY && HRESP) begin
                    // First ERROR cycle: withdraw the pending beat on the bus right away.
                    HTRANS   = TR_IDLE;
                    htrans_d = TR_IDLE;
                    state_d  = ST_ERR2;
                end else if (HREADY && HRESP) begin
                    htrans_d = TR_IDLE;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else if (HREADY) begin
                    if (!hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                    end
                    advance = 1'b1;
                end
            end
            ST_LAST: begin
                if (!HREADY && HRESP) begin
                    state_d = ST_ERR2;
                end else if (HREADY) begin
                    done_d  = 1'b1;
                    err_d   = HRESP;
                    state_d = ST_IDLE;
                    if (!hwrite_q && !HRESP) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                    end
                end
            end
            ST_ERR2: begin
                if (HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            wr_pop = hwrite_q;
            if (hwrite_q) begin
                hwdata_d = wr_data;
                hwstrb_d = strb;
            end
            if (beats_q == 5'd1) begin
                htrans_d = TR_IDLE;
                state_d  = ST_LAST;
            end else begin
                htrans_d = TR_SEQ;
                haddr_d  = next_addr;
                beats_d  = beats_q - 5'd1;
                state_d  = ST_PIPE;
            end
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hwdata_q    <= '0;
            hwstrb_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            hwstrb_q    <= hwstrb_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            beats_q     <= beats_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HWDATA    = hwdata_q;
    assign HWSTRB    = hwstrb_q;

endmodule

// File: tb/tb_ahb5_manager_engine.sv
// tb/tb_ahb5_manager_engine.sv - directed bench for ahb5_manager_engine
// A small subordinate model drives HREADY/HRESP/HRDATA; each test compares logged bus activity.
module tb_ahb5_manager_engine;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_size = '0;
    logic [2:0]  cmd_burst = '0;
    logic [3:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = '0;

    ahb5_manager_engine dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad = 0;

    logic [31:0] addr_log[$];
    logic [1:0]  trans_log[$];
    logic [2:0]  burst_log[$];
    logic [31:0] rdat_log[$];
    logic [31:0] wdat_log[$];
    logic [3:0]  strb_log[$];
    int          pop_cnt, done_cnt, hold_bad, stall_seen;
    logic        done_err, busy_ready;
    logic [1:0]  err_trans;

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [2:0] bu, input logic [3:0] ln,
                           input int stall_beat, input int stall_n, input int err_beat);
        logic        dp_valid, dp_write, stalled, fin, post_done;
        logic [31:0] dp_addr, hold_addr;
        logic [1:0]  hold_trans;
        int          dp_beat, beat, stall_cnt, err_ph;
        addr_log.delete(); trans_log.delete(); burst_log.delete();
        rdat_log.delete(); wdat_log.delete(); strb_log.delete();
        pop_cnt = 0; done_cnt = 0; hold_bad = 0; stall_seen = 0;
        done_err = 1'bx; busy_ready = 1'bx; err_trans = 2'b01;
        dp_valid = 0; dp_write = 0; dp_addr = '0; dp_beat = 0; beat = 0;
        stall_cnt = 0; err_ph = 0; fin = 0; post_done = 0;
        hold_addr = '0; hold_trans = '0;
        @(negedge HCLK);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_burst = bu; cmd_len = ln;
        HREADY = 1; HRESP = 0;
        @(negedge HCLK);
        cmd_valid = 0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            if (rd_valid) rdat_log.push_back(rd_data);
            if (done) begin
                done_cnt++;
                done_err = err;
                fin = 1;
            end
            if (!fin) begin
                if (cyc == 0) busy_ready = cmd_ready;
                stalled = 0;
                if (dp_valid && dp_beat == err_beat && err_ph == 0) begin
                    HREADY = 0; HRESP = 1; err_ph = 1;
                end else if (dp_valid && dp_beat == err_beat && err_ph == 1) begin
                    HREADY = 1; HRESP = 1; err_ph = 2;
                end else if (dp_valid && dp_beat == stall_beat && stall_cnt < stall_n) begin
                    HREADY = 0; HRESP = 0; stall_cnt++; stalled = 1; stall_seen++;
                end else begin
                    HREADY = 1; HRESP = 0;
                end
                HRDATA  = 32'hD000_0000 | dp_addr;
                wr_data = 32'hA5A5_1234 + pop_cnt;
                #1;
                if (err_ph == 1 && !HREADY) err_trans = HTRANS;
                if (stalled && stall_cnt == 1) begin
                    hold_addr = HADDR; hold_trans = HTRANS;
                end else if (stall_cnt > 0 && !post_done) begin
                    if (HADDR !== hold_addr || HTRANS !== hold_trans || HBURST !== bu) hold_bad++;
                    if (!stalled) post_done = 1;
                end
                if (wr_pop) pop_cnt++;
                if (dp_valid && HREADY && !HRESP && dp_write) begin
                    wdat_log.push_back(HWDATA);
                    strb_log.push_back(HWSTRB);
                end
                if (HREADY) begin
                    if (HTRANS[1]) begin
                        addr_log.push_back(HADDR);
                        trans_log.push_back(HTRANS);
                        burst_log.push_back(HBURST);
                        dp_valid = 1; dp_addr = HADDR; dp_write = HWRITE; dp_beat = beat; beat++;
                    end else begin
                        dp_valid = 0;
                    end
                end
                @(negedge HCLK);
            end
        end
        HREADY = 1; HRESP = 0;
    endtask

    task automatic test_reset();
        HRESETn = 0;
        repeat (2) @(negedge HCLK);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
        total++; if ({HTRANS, HADDR, HWSTRB, HWDATA} !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h/%h want=0", HTRANS, HADDR, HWSTRB, HWDATA); end
        total++; if ({done, err, rd_valid, wr_pop, rd_data} !== '0) begin bad++; $display("FAIL reset_status got=%b%b%b%b %h want=0", done, err, rd_valid, wr_pop, rd_data); end
        HRESETn = 1;
        @(negedge HCLK);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_write_single();
        run_cmd(1'b1, 32'h10, 3'd2, 3'd0, 4'd0, -1, 0, -1);
        total++; if (addr_log.size() != 1 || addr_log[0] !== 32'h10 || trans_log[0] !== 2'b10) begin bad++; $display("FAIL single_addr got n=%0d addr=%h want n=1 addr=00000010 NONSEQ", addr_log.size(), addr_log.size() ? addr_log[0] : 'x); end
        total++; if (strb_log.size() != 1 || strb_log[0] !== 4'hF || wdat_log[0] !== 32'hA5A5_1234) begin bad++; $display("FAIL single_wdata got n=%0d strb/data=%h/%h want F/a5a51234", strb_log.size(), strb_log.size() ? strb_log[0] : 'x, wdat_log.size() ? wdat_log[0] : 'x); end
        total++; if (pop_cnt != 1) begin bad++; $display("FAIL single_pops got=%0d want=1", pop_cnt); end
        total++; if (done_cnt != 1 || done_err !== 1'b0) begin bad++; $display("FAIL single_done got=%0d err=%b want=1 err=0", done_cnt, done_err); end
        total++; if (busy_ready !== 1'b0) begin bad++; $display("FAIL busy_cmd_ready got=%b want=0", busy_ready); end
    endtask

    task automatic test_read_incr4();
        logic [31:0] ea[4];
        logic [1:0]  et[4];
        ea = '{32'h20, 32'h24, 32'h28, 32'h2C};
        et = '{2'b10, 2'b11, 2'b11, 2'b11};
        run_cmd(1'b0, 32'h20, 3'd2, 3'd3, 4'd0, -1, 0, -1);
        total++; if (addr_log.size() != 4 || rdat_log.size() != 4) begin bad++; $display("FAIL incr4_counts got addr=%0d rd=%0d want 4/4", addr_log.size(), rdat_log.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ((i < addr_log.size() ? addr_log[i] : 'x) !== ea[i] || (i < trans_log.size() ? trans_log[i] : 'x) !== et[i] ||
                (i < rdat_log.size() ? rdat_log[i] : 'x) !== (32'hD000_0000 | ea[i])) begin
                bad++; $display("FAIL incr4_beat%0d got addr=%h trans=%h rd=%h want addr=%h trans=%h", i,
                    i < addr_log.size() ? addr_log[i] : 'x, i < trans_log.size() ? trans_log[i] : 'x,
                    i < rdat_log.size() ? rdat_log[i] : 'x, ea[i], et[i]);
            end
        end
        total++; if (done_cnt != 1 || done_err !== 1'b0) begin bad++; $display("FAIL incr4_done got=%0d err=%b want=1 err=0", done_cnt, done_err); end
    endtask

    task automatic test_write_wrap4();
        logic [31:0] ea[4];
        ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
        run_cmd(1'b1, 32'h38, 3'd2, 3'd2, 4'd0, -1, 0, -1);
        total++; if (addr_log.size() != 4 || wdat_log.size() != 4) begin bad++; $display("FAIL wrap4_counts got addr=%0d wd=%0d want 4/4", addr_log.size(), wdat_log.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ((i < addr_log.size() ? addr_log[i] : 'x) !== ea[i] || (i < burst_log.size() ? burst_log[i] : 'x) !== 3'd2 ||
                (i < wdat_log.size() ? wdat_log[i] : 'x) !== 32'hA5A5_1234 + i) begin
                bad++; $display("FAIL wrap4_beat%0d got addr=%h burst=%h wd=%h want addr=%h burst=2", i,
                    i < addr_log.size() ? addr_log[i] : 'x, i < burst_log.size() ? burst_log[i] : 'x,
                    i < wdat_log.size() ? wdat_log[i] : 'x, ea[i]);
            end
        end
    endtask

    task automatic test_incr8_stall();
        run_cmd(1'b0, 32'h100, 3'd2, 3'd5, 4'd0, 2, 2, -1);
        total++; if (stall_seen != 2 || hold_bad != 0) begin bad++; $display("FAIL stall_hold got stalls=%0d changes=%0d want 2/0", stall_seen, hold_bad); end
        total++; if (addr_log.size() != 8 || rdat_log.size() != 8) begin bad++; $display("FAIL stall_counts got addr=%0d rd=%0d want 8/8", addr_log.size(), rdat_log.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ((i < addr_log.size() ? addr_log[i] : 'x) !== 32'h100 + 4 * i || (i < rdat_log.size() ? rdat_log[i] : 'x) !== 32'hD000_0100 + 4 * i) begin
                bad++; $display("FAIL stall_beat%0d got addr=%h rd=%h want addr=%h", i,
                    i < addr_log.size() ? addr_log[i] : 'x, i < rdat_log.size() ? rdat_log[i] : 'x, 32'h100 + 4 * i);
            end
        end
        total++; if (done_cnt != 1 || done_err !== 1'b0) begin bad++; $display("FAIL stall_done got=%0d err=%b want=1 err=0", done_cnt, done_err); end
    endtask

    task automatic test_error();
        run_cmd(1'b0, 32'h20, 3'd2, 3'd3, 4'd0, -1, 0, 1);
        total++; if (err_trans !== 2'b00) begin bad++; $display("FAIL err_htrans got=%h want=0", err_trans); end
        total++; if (rdat_log.size() != 1 || rdat_log[0] !== 32'hD000_0020) begin bad++; $display("FAIL err_rd got n=%0d want n=1 d000_0020", rdat_log.size()); end
        total++; if (addr_log.size() != 2) begin bad++; $display("FAIL err_beats got=%0d want=2", addr_log.size()); end
        total++; if (done_cnt != 1 || done_err !== 1'b1) begin bad++; $display("FAIL err_done got=%0d err=%b want=1 err=1", done_cnt, done_err); end
        @(negedge HCLK);
        total++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL err_after got trans=%h ready=%b done=%b want 0/1/0", HTRANS, cmd_ready, done); end
    endtask

    task automatic test_halfword_reset();
        int late_done;
        run_cmd(1'b1, 32'h04, 3'd1, 3'd1, 4'd2, -1, 0, -1);
        total++; if (addr_log.size() != 3 || addr_log[0] !== 32'h04 || addr_log[1] !== 32'h06 || addr_log[2] !== 32'h08) begin bad++; $display("FAIL half_addr got n=%0d want 04,06,08", addr_log.size()); end
        total++; if (strb_log.size() != 3 || strb_log[0] !== 4'h3 || strb_log[1] !== 4'h3 || strb_log[2] !== 4'h3) begin bad++; $display("FAIL half_strb got n=%0d want three 3", strb_log.size()); end
        total++; if (pop_cnt != 3 || done_cnt != 1) begin bad++; $display("FAIL half_pops got pops=%0d done=%0d want 3/1", pop_cnt, done_cnt); end
        @(negedge HCLK);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h04; cmd_size = 3'd1; cmd_burst = 3'd1; cmd_len = 4'd2;
        HREADY = 1; HRESP = 0;
        @(negedge HCLK);
        cmd_valid = 0;
        @(negedge HCLK);
        #2 HRESETn = 0;
        #1;
        total++; if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB} !== '0) begin bad++; $display("FAIL midreset_bus got trans=%h addr=%h strb=%h wd=%h want 0", HTRANS, HADDR, HWSTRB, HWDATA); end
        total++; if ({cmd_ready, wr_pop, done, err, rd_valid} !== '0 || rd_data !== '0) begin bad++; $display("FAIL midreset_status got %b%b%b%b%b want 00000", cmd_ready, wr_pop, done, err, rd_valid); end
        @(negedge HCLK);
        HRESETn = 1;
        late_done = 0;
        @(negedge HCLK);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", cmd_ready); end
        repeat (4) begin
            @(negedge HCLK);
            if (done) late_done++;
        end
        total++; if (late_done != 0 || HTRANS !== 2'b00) begin bad++; $display("FAIL midreset_no_done got dones=%0d trans=%h want 0/0", late_done, HTRANS); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_incr4();
        test_write_wrap4();
        test_incr8_stall();
        test_error();
        test_halfword_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb5_manager_engine.md
AHB5_MANAGER_ENGINE -- requirements
Module: ahb5_manager_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (only 32 is supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter HBURST_WIDTH, default 3, HBURST width.
REQ-004 HCLK  in  1  single clock; all state updates on rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  command request; cmd_ready  out  1  engine accepts a command.
REQ-007 cmd_addr  in  ADDR_WIDTH  start address; cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_size  in  3  HSIZE code (0 byte, 1 halfword, 2 word).
REQ-009 cmd_burst  in  HBURST_WIDTH  HBURST code; cmd_len  in  4  beats-1, used only for INCR.
REQ-010 wr_data  in  DATA_WIDTH  next write beat, valid in the cycle wr_pop is high; wr_pop  out  1  write beat consumed.
REQ-011 rd_data  out  DATA_WIDTH  read beat; rd_valid  out  1  rd_data valid (1-cycle pulse).
REQ-012 done  out  1  command finished (1-cycle pulse); err  out  1  ERROR response seen, valid with done.
REQ-013 HADDR  out  ADDR_WIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  HBURST_WIDTH.
REQ-014 HWDATA  out  DATA_WIDTH; HWSTRB  out  DATA_WIDTH/8.
REQ-015 HREADY  in  1  transfer complete; HRESP  in  1  0 OKAY, 1 ERROR; HRDATA  in  DATA_WIDTH.

Function
REQ-016 SHALL implement states IDLE, ADDR (first address phase), PIPE (address n+1 overlapped with data n), LAST (final data phase only), ERR2 (second ERROR cycle).
REQ-017 IDLE: cmd_ready=1, HTRANS=IDLE; on cmd_valid, latch command and go to ADDR; cmd_ready=0 in all other states.
REQ-018 Beat count: SINGLE 1, INCR cmd_len+1, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16.
REQ-019 First beat SHALL drive HTRANS=NONSEQ; subsequent beats SEQ; HTRANS=IDLE when no beat is pending.
REQ-020 Address phase completes on a rising edge with HREADY=1; next beat address = current + (1<<size); WRAPn: low log2(n<<size) bits increment modulo, upper bits held.
REQ-021 On completion of the final address phase go to LAST (or to ADDR->LAST directly for 1 beat); otherwise ADDR/PIPE -> PIPE.
REQ-022 While HREADY=0, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB SHALL hold unchanged.
REQ-023 Write: HWDATA/HWSTRB load from wr_data when an address phase of a write beat completes; wr_pop pulses that same cycle; data LSB-aligned (lane 0), HWSTRB = (1<<(1<<size))-1 (byte 0x1, halfword 0x3, word 0xF).
REQ-024 Read: when a data phase completes with HREADY=1 and HRESP=0, rd_data=HRDATA registered and rd_valid pulses next cycle.
REQ-025 HRESP=1 with HREADY=0 (first ERROR cycle): drive HTRANS=IDLE that cycle, cancel remaining beats, go to ERR2.
REQ-026 ERR2: wait for HREADY=1 (HRESP=1); then pulse done with err=1, return to IDLE; no rd_valid for the errored beat.
REQ-027 LAST: on HREADY=1, HRESP=0, pulse done with err=0 next cycle (aligned with last rd_valid) and return to IDLE.
REQ-028 A new cmd_valid SHALL NOT be accepted until done has pulsed; cmd_size>2 SHALL be issued unchanged (subordinate returns ERROR).

Reset
REQ-029 On HRESETn=0, immediately: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, HWSTRB=0, rd_data=0, rd_valid=0, wr_pop=0, done=0, err=0, cmd_ready=0.
REQ-030 cmd_ready SHALL go to 1 on the first rising edge after HRESETn deasserts; reset mid-burst aborts with no done pulse.

Verification
REQ-031 Write SINGLE word 0x10, wr_data 0xA5A5_1234, HREADY=1 -> one NONSEQ at 0x10, HWSTRB=0xF, wr_pop once, done err=0.
REQ-032 Read INCR4 word from 0x20 -> HADDR 0x20,0x24,0x28,0x2C, NONSEQ,SEQ,SEQ,SEQ, four rd_valid in order, done with last.
REQ-033 Write WRAP4 word from 0x38 -> HADDR 0x38,0x3C,0x30,0x34; HBURST=WRAP4 held throughout.
REQ-034 INCR8 read with HREADY low 2 cycles on beat 3 -> all address/control held, no beat lost or duplicated, 8 rd_valid.
REQ-035 INCR4 read, HRESP=1 on beat 2 (HREADY 0 then 1) -> HTRANS=IDLE in first ERROR cycle, 1 rd_valid, done err=1, no further beats.
REQ-036 Halfword write INCR cmd_len=2 from 0x04 -> HADDR 0x04,0x06,0x08, HWSTRB=0x3, three wr_pop; reset asserted mid-burst -> all outputs at reset values at once.
